// File: rtl/slt_vector_checker.sv
`default_nettype none
// ============================================================================
//  Module      : slt_vector_checker
//  Description : Drives operand pairs into a 32-bit set-less-than unit, waits
//                a settle window, then checks its result against a signed
//                compare. Corner vectors first, then Galois-LFSR pairs.
//  Revision    : 1.0 - initial release
// ============================================================================
module slt_vector_checker #(
    parameter int NUM_VECTORS   = 256,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] seed,
    output logic [31:0] dut_a,
    output logic [31:0] dut_b,
    input  logic [31:0] dut_slt,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] error_count,
    output logic [31:0] first_fail_a,
    output logic [31:0] first_fail_b,
    output logic [31:0] first_fail_slt
);

    localparam logic [31:0] c_lfsr_mask  = 32'h80200003;
    localparam logic [31:0] c_num_corner = 32'd6;

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_apply  = 3'd1;
    localparam logic [2:0] c_st_settle = 3'd2;
    localparam logic [2:0] c_st_check  = 3'd3;
    localparam logic [2:0] c_st_done   = 3'd4;

    logic [2:0]  r_state;
    logic [31:0] r_idx;
    logic [31:0] r_cnt;
    logic [31:0] r_lfsr;
    logic [31:0] r_exp;

    logic [31:0] w_lfsr1;
    logic [31:0] w_lfsr2;
    logic        w_is_corner;
    logic [31:0] w_a;
    logic [31:0] w_b;
    logic [31:0] w_exp;
    logic        w_mismatch;
    logic        w_start_ok;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? c_lfsr_mask : 32'h0);
    endfunction

    function automatic logic [63:0] corner_ab(input logic [2:0] i);
        logic [63:0] v;
        case (i)
            3'd0:    v = {32'h80000100, 32'h02082100};
            3'd1:    v = {32'h82082100, 32'h82082100};
            3'd2:    v = {32'h82082100, 32'h80000000};
            3'd3:    v = {32'h02303003, 32'hFFC1FE0F};
            3'd4:    v = {32'hFFC1FE0F, 32'h02303003};
            default: v = {32'h7FFFFFFF, 32'h80000000};
        endcase
        return v;
    endfunction

    // A random vector takes two consecutive LFSR states as its operands
    assign w_lfsr1     = lfsr_step(r_lfsr);
    assign w_lfsr2     = lfsr_step(w_lfsr1);
    assign w_is_corner = (r_idx < c_num_corner);

    always_comb begin
        w_a = r_lfsr;
        w_b = w_lfsr1;
        if (w_is_corner) begin
            {w_a, w_b} = corner_ab(r_idx[2:0]);
        end
    end

    assign w_exp      = ($signed(w_a) < $signed(w_b)) ? 32'd1 : 32'd0;
    assign w_mismatch = (dut_slt != r_exp);
    assign w_start_ok = start && ((r_state == c_st_idle) || (r_state == c_st_done));

    assign busy = (r_state == c_st_apply) || (r_state == c_st_settle) || (r_state == c_st_check);
    assign done = (r_state == c_st_done);
    assign pass = done && (error_count == 16'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= c_st_idle;
            r_idx          <= 32'd0;
            r_cnt          <= 32'd0;
            r_lfsr         <= 32'd0;
            r_exp          <= 32'd0;
            dut_a          <= 32'd0;
            dut_b          <= 32'd0;
            error_count    <= 16'd0;
            first_fail_a   <= 32'd0;
            first_fail_b   <= 32'd0;
            first_fail_slt <= 32'd0;
        end else begin
            case (r_state)
                c_st_idle, c_st_done: begin
                    if (w_start_ok) begin
                        r_state        <= c_st_apply;
                        r_idx          <= 32'd0;
                        r_lfsr         <= (seed == 32'd0) ? 32'h00000001 : seed;
                        error_count    <= 16'd0;
                        first_fail_a   <= 32'd0;
                        first_fail_b   <= 32'd0;
                        first_fail_slt <= 32'd0;
                    end
                end
                c_st_apply: begin
                    dut_a   <= w_a;
                    dut_b   <= w_b;
                    r_exp   <= w_exp;
                    r_cnt   <= 32'(SETTLE_CYCLES - 1);
                    r_state <= c_st_settle;
                    if (!w_is_corner) begin
                        r_lfsr <= w_lfsr2;
                    end
                end
                c_st_settle: begin
                    if (r_cnt == 32'd0) begin
                        r_state <= c_st_check;
                    end else begin
                        r_cnt <= r_cnt - 32'd1;
                    end
                end
                c_st_check: begin
                    if (w_mismatch) begin
                        // A zero count means no earlier failure in this run
                        if (error_count == 16'd0) begin
                            first_fail_a   <= dut_a;
                            first_fail_b   <= dut_b;
                            first_fail_slt <= dut_slt;
                        end
                        if (error_count != 16'hFFFF) begin
                            error_count <= error_count + 16'd1;
                        end
                    end
                    if (r_idx == 32'(NUM_VECTORS - 1)) begin
                        r_state <= c_st_done;
                    end else begin
                        r_idx   <= r_idx + 32'd1;
                        r_state <= c_st_apply;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_slt_vector_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_slt_vector_checker
//  Description : Self-checking bench for slt_vector_checker with a selectable
//                behavioural SLT unit on the far side of the a/b/slt interface.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_slt_vector_checker;

    localparam int NV = 256;
    localparam int ST = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] seed;
    logic [31:0] dut_a;
    logic [31:0] dut_b;
    logic [31:0] dut_slt;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] error_count;
    logic [31:0] first_fail_a;
    logic [31:0] first_fail_b;
    logic [31:0] first_fail_slt;

    int mode;
    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        int          mode;
        logic [31:0] seed;
        int          pulse_v;
        int          abort_v;
    } run_t;

    vec_t corner[6];
    run_t runs[6];
    vec_t sb[$];

    slt_vector_checker #(.NUM_VECTORS(NV), .SETTLE_CYCLES(ST)) u_dut (
        .clk(clk), .reset(reset), .start(start), .seed(seed),
        .dut_a(dut_a), .dut_b(dut_b), .dut_slt(dut_slt),
        .busy(busy), .done(done), .pass(pass), .error_count(error_count),
        .first_fail_a(first_fail_a), .first_fail_b(first_fail_b),
        .first_fail_slt(first_fail_slt)
    );

    always #5 clk = ~clk;

    // Modes: 0 ideal signed, 1 stuck at 0, 2 unsigned compare, 3 returns 2 for true
    function automatic logic [31:0] slt_model(input logic [31:0] a, input logic [31:0] b, input int m);
        logic [31:0] r;
        case (m)
            1:       r = 32'd0;
            2:       r = (a < b) ? 32'd1 : 32'd0;
            3:       r = ($signed(a) < $signed(b)) ? 32'd2 : 32'd0;
            default: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        endcase
        return r;
    endfunction

    always_comb dut_slt = slt_model(dut_a, dut_b, mode);

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        logic [31:0] n;
        n = s >> 1;
        if (s[0]) n = n ^ 32'h80200003;
        return n;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic build_sb(input logic [31:0] sd);
        logic [31:0] s;
        vec_t        e;
        sb.delete();
        s = (sd == 32'd0) ? 32'd1 : sd;
        for (int v = 0; v < NV; v++) begin
            if (v < 6) begin
                e = corner[v];
            end else begin
                e.a   = s;
                e.b   = lfsr_next(s);
                s     = lfsr_next(e.b);
                e.exp = ($signed(e.a) < $signed(e.b)) ? 32'd1 : 32'd0;
            end
            sb.push_back(e);
        end
    endtask

    task automatic do_run(input run_t r);
        vec_t        e;
        logic [31:0] ff_a, ff_b, ff_slt, last_a, last_b, got;
        int          errs;
        int          w;
        int          skip;
        build_sb(r.seed);
        mode   = r.mode;
        errs   = 0;
        ff_a   = 32'd0;
        ff_b   = 32'd0;
        ff_slt = 32'd0;
        for (int i = 0; i < sb.size(); i++) begin
            got = slt_model(sb[i].a, sb[i].b, r.mode);
            if (got != sb[i].exp) begin
                if (errs == 0) begin
                    ff_a   = sb[i].a;
                    ff_b   = sb[i].b;
                    ff_slt = got;
                end
                errs++;
            end
        end
        last_a = 32'd0;
        last_b = 32'd0;
        skip   = 0;
        @(posedge clk); #1;
        seed  = r.seed;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int v = 0; v < NV; v++) begin
            w = ((v == 0) ? 1 : ST + 2) - skip;
            skip = 0;
            repeat (w) @(posedge clk);
            #1;
            e = sb.pop_front();
            chk($sformatf("dut_a[%0d]", v), dut_a, e.a);
            chk($sformatf("dut_b[%0d]", v), dut_b, e.b);
            chk($sformatf("busy[%0d]", v), {31'd0, busy}, 32'd1);
            last_a = e.a;
            last_b = e.b;
            if (v == 0) begin
                chk("err_cleared", {16'd0, error_count}, 32'd0);
                chk("ffa_cleared", first_fail_a, 32'd0);
                chk("ffslt_cleared", first_fail_slt, 32'd0);
            end
            if (v == r.abort_v) begin
                @(posedge clk); #1;
                reset = 1'b1;
                #1;
                chk("abort_busy", {31'd0, busy}, 32'd0);
                chk("abort_done", {31'd0, done}, 32'd0);
                chk("abort_a", dut_a, 32'd0);
                chk("abort_b", dut_b, 32'd0);
                chk("abort_err", {16'd0, error_count}, 32'd0);
                chk("abort_ffa", first_fail_a, 32'd0);
                @(posedge clk); #1;
                reset = 1'b0;
                return;
            end
            if (v == r.pulse_v) begin
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
                skip = 1;
            end
        end
        repeat (ST) @(posedge clk);
        #1;
        chk("done_early", {31'd0, done}, 32'd0);
        @(posedge clk); #1;
        chk("done_on_time", {31'd0, done}, 32'd1);
        chk("busy_in_done", {31'd0, busy}, 32'd0);
        chk("pass", {31'd0, pass}, (errs == 0) ? 32'd1 : 32'd0);
        chk("error_count", {16'd0, error_count}, 32'(errs));
        chk("first_fail_a", first_fail_a, ff_a);
        chk("first_fail_b", first_fail_b, ff_b);
        chk("first_fail_slt", first_fail_slt, ff_slt);
        repeat (3) @(posedge clk);
        #1;
        chk("hold_done", {31'd0, done}, 32'd1);
        chk("hold_a", dut_a, last_a);
        chk("hold_b", dut_b, last_b);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        corner[0] = '{32'h80000100, 32'h02082100, 32'd1};
        corner[1] = '{32'h82082100, 32'h82082100, 32'd0};
        corner[2] = '{32'h82082100, 32'h80000000, 32'd0};
        corner[3] = '{32'h02303003, 32'hFFC1FE0F, 32'd0};
        corner[4] = '{32'hFFC1FE0F, 32'h02303003, 32'd1};
        corner[5] = '{32'h7FFFFFFF, 32'h80000000, 32'd0};

        runs[0] = '{0, 32'h12345678, -1, -1};
        runs[1] = '{1, 32'h12345678, -1, -1};
        runs[2] = '{2, 32'hDEADBEEF, -1, -1};
        runs[3] = '{3, 32'h00000000, -1, -1};
        runs[4] = '{0, 32'h12345678, -1, 10};
        runs[5] = '{0, 32'h12345678, 3, -1};

        mode  = 0;
        reset = 1'b1;
        start = 1'b0;
        seed  = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_pass", {31'd0, pass}, 32'd0);
        chk("rst_a", dut_a, 32'd0);
        chk("rst_b", dut_b, 32'd0);
        chk("rst_err", {16'd0, error_count}, 32'd0);
        chk("rst_ffa", first_fail_a, 32'd0);
        chk("rst_ffb", first_fail_b, 32'd0);
        chk("rst_ffslt", first_fail_slt, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            do_run(runs[i]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/slt_vector_checker.md
Name: slt_vector_checker

Overview:
- Sequential stimulus driver and response checker for the 32-bit set-less-than unit; it sits on the opposite end of that unit's a/b/slt interface.
- Drives operand pairs onto dut_a/dut_b, waits a settle window, then samples dut_slt and compares all 32 bits against an internal signed-compare model.
- Applies a fixed corner-case table first, then LFSR pseudo-random pairs.
- Reports pass/fail, the error count and the first failing vector, for on-board self-test of the ALU.

Parameters:
- NUM_VECTORS, 256, total vectors per run including the corner table (legal values ≥ 6).
- SETTLE_CYCLES, 4, cycles the operands are held before dut_slt is sampled (legal values ≥ 1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  one-cycle pulse that begins a run; honoured only in IDLE or DONE.
- seed  in  32  LFSR seed, captured on start; 0 is replaced by 32'h00000001.
- dut_a  out  32  operand A driven to the SLT unit.
- dut_b  out  32  operand B driven to the SLT unit.
- dut_slt  in  32  SLT unit result.
- busy  out  1  high in APPLY/SETTLE/CHECK.
- done  out  1  high in DONE.
- pass  out  1  done && error_count==0.
- error_count  out  16  number of mismatching vectors; saturates at 16'hFFFF.
- first_fail_a  out  32  A of the first mismatch (0 if none).
- first_fail_b  out  32  B of the first mismatch (0 if none).
- first_fail_slt  out  32  dut_slt observed at the first mismatch.

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0; vector index 0; internal expected value 0. A reset mid-run aborts the run with no partial result.
- Expected value: 32'd1 if $signed(A) < $signed(B), else 32'd0. All 32 bits are compared, so any nonzero upper bit is an error.
- Corner table, vector indices 0..5 (A, B, expected):
  - 0x80000100, 0x02082100, 1
  - 0x82082100, 0x82082100, 0
  - 0x82082100, 0x80000000, 0
  - 0x02303003, 0xFFC1FE0F, 0
  - 0xFFC1FE0F, 0x02303003, 1
  - 0x7FFFFFFF, 0x80000000, 0
- Random vectors, indices 6..NUM_VECTORS-1:
  - Galois LFSR, polynomial x^32+x^22+x^2+x+1, mask 32'h80200003, shifting right.
  - Per vector: A = current LFSR state; B = state after one step; the LFSR then advances two steps.
- FSM states and transitions:
  - IDLE / DONE --start--> APPLY.
  - APPLY (1 cycle): register dut_a/dut_b and the expected value for the current index; load the settle counter with SETTLE_CYCLES-1; go to SETTLE.
  - SETTLE: decrement the counter each cycle; when the counter is 0, go to CHECK. SETTLE lasts exactly SETTLE_CYCLES cycles.
  - CHECK (1 cycle): sample dut_slt. On mismatch, increment error_count (saturating); if this is the first mismatch, latch first_fail_*. Then go to DONE if index==NUM_VECTORS-1, else increment the index and go to APPLY.
  - dut_a/dut_b hold their value from APPLY through CHECK, and in DONE.
- Latency: done rises exactly NUM_VECTORS*(SETTLE_CYCLES+2) cycles after the edge that samples start.
- start while busy is ignored.
- start in DONE:
  - clears error_count and first_fail_*;
  - recaptures seed;
  - restarts at index 0.
- done, pass and first_fail_* hold in DONE until the next start or reset.

Test Plan:
- Ideal combinational SLT model connected, NUM_VECTORS=256, SETTLE_CYCLES=4, seed=0x12345678 -> done exactly 1536 cycles after start; pass=1; error_count=0.
- Model stuck at 32'd0 -> first_fail_a=0x80000100, first_fail_b=0x02082100, first_fail_slt=0; error_count equals the number of expected-1 vectors (including corner index 4); pass=0.
- Model returning an unsigned compare -> index 0 (0x80000100 vs 0x02082100) fails first with first_fail_slt=0; corner index 5 also mismatches.
- Model returning 32'h00000002 in place of 1 -> every expected-1 vector counts as an error, confirming the upper bits are checked.
- Assert reset mid-SETTLE on vector 10 -> outputs 0 and IDLE immediately; a new start reruns from index 0 with identical dut_a/dut_b sequence.
- start pulsed while busy -> ignored and the run completes on schedule. seed=0 gives the same vector stream as seed=1.
